issue_ctrl: RTL and testbench
=============================

# issue_ctrl

Dual-issue pairing controller between ID and EX. Accepts a decoded two-instruction bundle and decides whether both slots issue together. A bundle is split when slot 1 depends on slot 0 (RAW or WAW); slot 0 issues first and slot 1 issues in the next issue slot. A one-cycle bubble is inserted when a candidate reads the destination of a load already in the issue register. Drives the ID/EX issue register with a valid/ready handshake toward EX.

## Interface
- INST_W, 32, instruction word width carried per slot
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- io_in_valid  in  1  ID bundle valid (slot 0 always present when set)
- io_in_ready  out  1  bundle accepted this cycle when io_in_valid & io_in_ready
- io_in_inst_0 / io_in_inst_1  in  INST_W  instruction words
- io_in_valid_1  in  1  slot 1 present
- io_in_rs1_0, io_in_rs2_0, io_in_rd_0, io_in_rs1_1, io_in_rs2_1, io_in_rd_1  in  5 each  register indices
- io_in_rdwen_0 / io_in_rdwen_1  in  1  slot writes rd
- io_in_isload_0 / io_in_isload_1  in  1  slot is a load
- io_flush  in  1  synchronous pipeline flush
- io_out_valid_0 / io_out_valid_1  out  1  issue register slot valid
- io_out_inst_0 / io_out_inst_1  out  INST_W  issue register contents
- io_out_ready  in  1  EX consumes the issue register this cycle

## Operation
- Issue register R holds, per slot: valid, inst, rd, rdwen, isload.
- adv = !io_out_valid_0 | io_out_ready. R loads only when adv = 1.
- dep = valid_1 & rdwen_0 & rd_0 != 0 & (rd_0 == rs1_1 | rd_0 == rs2_1 | (rdwen_1 & rd_0 == rd_1)).
- luse(cand) = 1 if some R slot k has valid & isload & rdwen & rd != 0, and rd_k equals rs1 or rs2 of any valid candidate instruction.
- The FSM has two states.
- PAIR state: io_in_ready = adv & !luse(in) & !io_flush.
  - If io_in_valid, adv, and luse(in): load a bubble (both R valids 0) and hold the bundle. This counts as one bubble.
  - On accept with dep = 1: R slot 0 = slot 0, R slot 1 invalid. Latch slot 1 into hold buffer H. Go to SPLIT. This counts as one split.
  - On accept with dep = 0: R gets both slots. valid_1 is copied from io_in_valid_1.
  - If adv and the bundle is not accepted: R valids go to 0.
- SPLIT state: io_in_ready = 0.
  - If adv & luse(H): load a bubble and stay in SPLIT.
  - If adv & !luse(H): R slot 0 = H, R slot 1 invalid. Go to PAIR.
- Flush has priority over everything. R valids clear, H clears, state goes to PAIR, and io_in_ready = 0.
- A slot-0 load followed by a dependent slot 1 produces split, then bubble, then slot 1.

## Timing
- Reset values: R valids 0, state PAIR, H invalid, io_out_valid_0/1 = 0.
- io_out_inst_0/1 are 0 at reset. After reset they are don't-care while invalid.
- Latency from accept to io_out_valid_0 is 1 cycle.
- Split slot 1 appears no earlier than 1 cycle after slot 0 leaves R.
- While !io_out_ready and R is valid, R and state hold.
- io_in_ready is combinational from R, state, io_out_ready, io_flush and the ID inputs. There is no path from io_in_valid to io_in_ready.
- Reset mid-SPLIT discards H.
- Flush in the same cycle as an accept: the accept does not occur.

## Configuration
- ISSUE_CTRL_PERF_EN defined: adds io_perf_split (out, 32) and io_perf_bubble (out, 32).
  - Free-running counters, reset to 0, wrapping at 2^32.
  - io_perf_split increments once per split bundle accepted.
  - io_perf_bubble increments once per cycle a load-use bubble is loaded into R.
  - Flush does not clear them.
- Not defined: ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package issue_pkg contains the state enum (ST_PAIR, ST_SPLIT), the slot struct (valid, inst, rd, rdwen, isload), and the REG_ZERO constant 5'd0.
- One sub-module, issue_hazard: combinational dep and luse comparators, instantiated once for the ID bundle and once for H.

## Test plan
- Independent pair: inst_0 writes x1, inst_1 reads x2/x3 -> next cycle both R valids are 1, io_in_ready stays 1.
- RAW split: rd_0 = 5, rs1_1 = 5 -> cycle 1: only slot 0 is valid and io_in_ready = 0. Cycle 2: held inst_1 is in slot 0. io_perf_split = 1.
- rd_0 = 0 with rs1_1 = 0 -> no split.
- Load-use: R holds a load to x7 and the new bundle slot 0 reads x7 -> one bubble cycle, bundle issues the following cycle, io_perf_bubble = 1.
- Backpressure: io_out_ready = 0 for 3 cycles with R valid -> R is unchanged and io_in_ready = 0. The bundle issues on the cycle after ready returns.
- Flush in SPLIT -> next cycle R valids are 0, state is PAIR, H is discarded, and io_in_ready = 1 when io_out_ready = 1.
- Async reset asserted mid-split -> outputs are 0 immediately and counters are 0.

Source files
------------

// File: rtl/issue_pkg.sv
// issue_pkg: shared types and constants for the dual-issue pairing controller.
//   ISSUE_INST_W  - instruction word width stored per issue slot
//   REG_ZERO      - architectural zero register index (never a real dependency)
//   issue_state_e - pairing FSM state (ST_PAIR, ST_SPLIT)
//   issue_slot_t  - one issue-register slot (valid, inst, rd, rdwen, isload)
package issue_pkg;

    localparam int unsigned ISSUE_INST_W = 32;
    localparam logic [4:0]  REG_ZERO     = 5'd0;

    typedef enum logic {
        ST_PAIR  = 1'b0,
        ST_SPLIT = 1'b1
    } issue_state_e;

    typedef struct packed {
        logic                    valid;
        logic [ISSUE_INST_W-1:0] inst;
        logic [4:0]              rd;
        logic                    rdwen;
        logic                    isload;
    } issue_slot_t;

endpackage

// File: rtl/issue_hazard.sv
// issue_hazard: combinational hazard comparators for a one- or two-instruction candidate.
//   cand_*_0_i / cand_*_1_i - candidate slot 0 / slot 1 (valid, rs1, rs2, rd, rdwen)
//   r_*_i                   - issue-register slot state (valid, isload, rdwen, rd)
//   dep_o                   - slot 1 depends on slot 0 (RAW or WAW), so the pair must split
//   luse_o                  - a candidate reads the destination of a load sitting in R
module issue_hazard
    import issue_pkg::*;
(
    input  logic       cand_valid_0_i,
    input  logic [4:0] cand_rs1_0_i,
    input  logic [4:0] cand_rs2_0_i,
    input  logic [4:0] cand_rd_0_i,
    input  logic       cand_rdwen_0_i,
    input  logic       cand_valid_1_i,
    input  logic [4:0] cand_rs1_1_i,
    input  logic [4:0] cand_rs2_1_i,
    input  logic [4:0] cand_rd_1_i,
    input  logic       cand_rdwen_1_i,
    input  logic [1:0] r_valid_i,
    input  logic [1:0] r_isload_i,
    input  logic [1:0] r_rdwen_i,
    input  logic [4:0] r_rd_0_i,
    input  logic [4:0] r_rd_1_i,
    output logic       dep_o,
    output logic       luse_o
);

    logic [1:0] load_pending;
    logic [1:0] load_hit;

    assign dep_o = cand_valid_1_i & cand_rdwen_0_i & (cand_rd_0_i != REG_ZERO) &
                   ((cand_rd_0_i == cand_rs1_1_i) | (cand_rd_0_i == cand_rs2_1_i) |
                    (cand_rdwen_1_i & (cand_rd_0_i == cand_rd_1_i)));

    // A load in R whose result is not yet available to the next issue slot.
    assign load_pending[0] = r_valid_i[0] & r_isload_i[0] & r_rdwen_i[0] &
                             (r_rd_0_i != REG_ZERO);
    assign load_pending[1] = r_valid_i[1] & r_isload_i[1] & r_rdwen_i[1] &
                             (r_rd_1_i != REG_ZERO);

    assign load_hit[0] =
        (cand_valid_0_i & ((cand_rs1_0_i == r_rd_0_i) | (cand_rs2_0_i == r_rd_0_i))) |
        (cand_valid_1_i & ((cand_rs1_1_i == r_rd_0_i) | (cand_rs2_1_i == r_rd_0_i)));
    assign load_hit[1] =
        (cand_valid_0_i & ((cand_rs1_0_i == r_rd_1_i) | (cand_rs2_0_i == r_rd_1_i))) |
        (cand_valid_1_i & ((cand_rs1_1_i == r_rd_1_i) | (cand_rs2_1_i == r_rd_1_i)));

    assign luse_o = |(load_pending & load_hit);

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: dual-issue pairing controller between ID and EX.
// Accepts a two-instruction bundle from ID and loads the ID/EX issue register R. Dependent
// pairs are split (slot 1 parked in hold buffer H and issued next), and a bubble is inserted
// when a candidate reads the destination of a load already in R.
// Ports:
//   clock, reset                 - clock, asynchronous active-high reset
//   io_in_valid / io_in_ready    - ID bundle handshake
//   io_in_inst_*, io_in_rs*_*, io_in_rd_*, io_in_rdwen_*, io_in_isload_*, io_in_valid_1
//                                - decoded bundle fields
//   io_flush                     - synchronous flush, highest priority
//   io_out_valid_*, io_out_inst_* - issue register contents toward EX
//   io_out_ready                 - EX consumes R this cycle
//   io_perf_split, io_perf_bubble - performance counters (only with ISSUE_CTRL_PERF_EN)
// Build option: define ISSUE_CTRL_PERF_EN to add the split/bubble performance counters.
// INST_W must not exceed issue_pkg::ISSUE_INST_W, which sizes the stored slot.
module issue_ctrl
    import issue_pkg::*;
#(
    parameter int unsigned INST_W = ISSUE_INST_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [INST_W-1:0] io_in_inst_0,
    input  logic [INST_W-1:0] io_in_inst_1,
    input  logic              io_in_valid_1,
    input  logic [4:0]        io_in_rs1_0,
    input  logic [4:0]        io_in_rs2_0,
    input  logic [4:0]        io_in_rd_0,
    input  logic [4:0]        io_in_rs1_1,
    input  logic [4:0]        io_in_rs2_1,
    input  logic [4:0]        io_in_rd_1,
    input  logic              io_in_rdwen_0,
    input  logic              io_in_rdwen_1,
    input  logic              io_in_isload_0,
    input  logic              io_in_isload_1,
    input  logic              io_flush,
    output logic              io_out_valid_0,
    output logic              io_out_valid_1,
    output logic [INST_W-1:0] io_out_inst_0,
    output logic [INST_W-1:0] io_out_inst_1,
`ifdef ISSUE_CTRL_PERF_EN
    output logic [31:0]       io_perf_split,
    output logic [31:0]       io_perf_bubble,
`endif
    input  logic              io_out_ready
);

    issue_state_e state_q, state_d;
    issue_slot_t  r0_q, r0_d;
    issue_slot_t  r1_q, r1_d;
    issue_slot_t  h_q, h_d;
    logic [4:0]   h_rs1_q, h_rs1_d;
    logic [4:0]   h_rs2_q, h_rs2_d;

    issue_slot_t  in_slot_0;
    issue_slot_t  in_slot_1;
    logic         adv;
    logic         accept;
    logic         in_dep;
    logic         in_luse;
    logic         h_dep;
    logic         h_luse;

    // ID bundle: slot 0 is treated as present so io_in_ready never depends on io_in_valid.
    issue_hazard u_hazard_in (
        .cand_valid_0_i (1'b1),
        .cand_rs1_0_i   (io_in_rs1_0),
        .cand_rs2_0_i   (io_in_rs2_0),
        .cand_rd_0_i    (io_in_rd_0),
        .cand_rdwen_0_i (io_in_rdwen_0),
        .cand_valid_1_i (io_in_valid_1),
        .cand_rs1_1_i   (io_in_rs1_1),
        .cand_rs2_1_i   (io_in_rs2_1),
        .cand_rd_1_i    (io_in_rd_1),
        .cand_rdwen_1_i (io_in_rdwen_1),
        .r_valid_i      ({r1_q.valid, r0_q.valid}),
        .r_isload_i     ({r1_q.isload, r0_q.isload}),
        .r_rdwen_i      ({r1_q.rdwen, r0_q.rdwen}),
        .r_rd_0_i       (r0_q.rd),
        .r_rd_1_i       (r1_q.rd),
        .dep_o          (in_dep),
        .luse_o         (in_luse)
    );

    // Hold buffer: a lone instruction, so only its load-use result matters.
    issue_hazard u_hazard_h (
        .cand_valid_0_i (h_q.valid),
        .cand_rs1_0_i   (h_rs1_q),
        .cand_rs2_0_i   (h_rs2_q),
        .cand_rd_0_i    (h_q.rd),
        .cand_rdwen_0_i (h_q.rdwen),
        .cand_valid_1_i (1'b0),
        .cand_rs1_1_i   (REG_ZERO),
        .cand_rs2_1_i   (REG_ZERO),
        .cand_rd_1_i    (REG_ZERO),
        .cand_rdwen_1_i (1'b0),
        .r_valid_i      ({r1_q.valid, r0_q.valid}),
        .r_isload_i     ({r1_q.isload, r0_q.isload}),
        .r_rdwen_i      ({r1_q.rdwen, r0_q.rdwen}),
        .r_rd_0_i       (r0_q.rd),
        .r_rd_1_i       (r1_q.rd),
        .dep_o          (h_dep),
        .luse_o         (h_luse)
    );

    always_comb begin
        in_slot_0        = '0;
        in_slot_0.valid  = 1'b1;
        in_slot_0.inst   = io_in_inst_0;
        in_slot_0.rd     = io_in_rd_0;
        in_slot_0.rdwen  = io_in_rdwen_0;
        in_slot_0.isload = io_in_isload_0;

        in_slot_1        = '0;
        in_slot_1.valid  = io_in_valid_1;
        in_slot_1.inst   = io_in_inst_1;
        in_slot_1.rd     = io_in_rd_1;
        in_slot_1.rdwen  = io_in_rdwen_1;
        in_slot_1.isload = io_in_isload_1;
    end

    assign adv         = ~r0_q.valid | io_out_ready;
    assign io_in_ready = (state_q == ST_PAIR) & adv & ~in_luse & ~io_flush;
    assign accept      = io_in_valid & io_in_ready;

    always_comb begin
        // Slot 1 of the hazard unit is tied off for H, so a pair dependency cannot exist.
        assert (!h_dep);

        state_d = state_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        h_d     = h_q;
        h_rs1_d = h_rs1_q;
        h_rs2_d = h_rs2_q;

        if (io_flush) begin
            r0_d.valid = 1'b0;
            r1_d.valid = 1'b0;
            h_d.valid  = 1'b0;
            state_d    = ST_PAIR;
        end else begin
            case (state_q)
                ST_PAIR: begin
                    if (adv) begin
                        if (accept) begin
                            r0_d = in_slot_0;
                            if (in_dep) begin
                                r1_d.valid = 1'b0;
                                h_d        = in_slot_1;
                                h_rs1_d    = io_in_rs1_1;
                                h_rs2_d    = io_in_rs2_1;
                                state_d    = ST_SPLIT;
                            end else begin
                                r1_d = in_slot_1;
                            end
                        end else begin
                            // Empty issue slot: either nothing offered or a load-use bubble.
                            r0_d.valid = 1'b0;
                            r1_d.valid = 1'b0;
                        end
                    end
                end
                ST_SPLIT: begin
                    if (adv) begin
                        r1_d.valid = 1'b0;
                        if (h_luse) begin
                            r0_d.valid = 1'b0;
                        end else begin
                            r0_d      = h_q;
                            h_d.valid = 1'b0;
                            state_d   = ST_PAIR;
                        end
                    end
                end
                default: state_d = ST_PAIR;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_PAIR;
            r0_q    <= '0;
            r1_q    <= '0;
            h_q     <= '0;
            h_rs1_q <= REG_ZERO;
            h_rs2_q <= REG_ZERO;
        end else begin
            state_q <= state_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            h_q     <= h_d;
            h_rs1_q <= h_rs1_d;
            h_rs2_q <= h_rs2_d;
        end
    end

    assign io_out_valid_0 = r0_q.valid;
    assign io_out_valid_1 = r1_q.valid;
    assign io_out_inst_0  = r0_q.inst;
    assign io_out_inst_1  = r1_q.inst;

`ifdef ISSUE_CTRL_PERF_EN
    logic        split_evt;
    logic        bubble_evt;
    logic [31:0] perf_split_q;
    logic [31:0] perf_bubble_q;

    // accept already excludes flush and SPLIT state.
    assign split_evt  = accept & in_dep;
    assign bubble_evt = ~io_flush & adv &
                        (((state_q == ST_PAIR) & io_in_valid & in_luse) |
                         ((state_q == ST_SPLIT) & h_luse));

    // Free-running, wrap at 2^32; flush deliberately leaves them alone.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_split_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            if (split_evt) begin
                perf_split_q <= perf_split_q + 32'd1;
            end
            if (bubble_evt) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign io_perf_split  = perf_split_q;
    assign io_perf_bubble = perf_bubble_q;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed self-checking bench for issue_ctrl.
// Performance counter checks are compiled in when ISSUE_CTRL_PERF_EN is defined.
module tb_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst_0;
    logic [31:0] inst_1;
    logic        valid_1;
    logic [4:0]  rs1_0, rs2_0, rd_0, rs1_1, rs2_1, rd_1;
    logic        rdwen_0, rdwen_1, isload_0, isload_1;
    logic        flush;
    logic        out_valid_0, out_valid_1;
    logic [31:0] out_inst_0, out_inst_1;
    logic        out_ready;
`ifdef ISSUE_CTRL_PERF_EN
    logic [31:0] perf_split;
    logic [31:0] perf_bubble;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    issue_ctrl #(.INST_W(32)) dut (
        .clock          (clk),
        .reset          (rst),
        .io_in_valid    (in_valid),
        .io_in_ready    (in_ready),
        .io_in_inst_0   (inst_0),
        .io_in_inst_1   (inst_1),
        .io_in_valid_1  (valid_1),
        .io_in_rs1_0    (rs1_0),
        .io_in_rs2_0    (rs2_0),
        .io_in_rd_0     (rd_0),
        .io_in_rs1_1    (rs1_1),
        .io_in_rs2_1    (rs2_1),
        .io_in_rd_1     (rd_1),
        .io_in_rdwen_0  (rdwen_0),
        .io_in_rdwen_1  (rdwen_1),
        .io_in_isload_0 (isload_0),
        .io_in_isload_1 (isload_1),
        .io_flush       (flush),
        .io_out_valid_0 (out_valid_0),
        .io_out_valid_1 (out_valid_1),
        .io_out_inst_0  (out_inst_0),
        .io_out_inst_1  (out_inst_1),
`ifdef ISSUE_CTRL_PERF_EN
        .io_perf_split  (perf_split),
        .io_perf_bubble (perf_bubble),
`endif
        .io_out_ready   (out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; valid_1 = 1'b0; inst_0 = '0; inst_1 = '0;
        rs1_0 = '0; rs2_0 = '0; rd_0 = '0; rdwen_0 = 1'b0; isload_0 = 1'b0;
        rs1_1 = '0; rs2_1 = '0; rd_1 = '0; rdwen_1 = 1'b0; isload_1 = 1'b0;
    endtask

    task automatic drive_slot0(input logic [31:0] inst, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic rdwen, input logic isload);
        in_valid = 1'b1; inst_0 = inst; rs1_0 = rs1; rs2_0 = rs2; rd_0 = rd;
        rdwen_0 = rdwen; isload_0 = isload;
    endtask

    task automatic drive_slot1(input logic [31:0] inst, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic rdwen, input logic isload);
        valid_1 = 1'b1; inst_1 = inst; rs1_1 = rs1; rs2_1 = rs2; rd_1 = rd;
        rdwen_1 = rdwen; isload_1 = isload;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive_idle();
        step();
        step();
        checks++; if (out_valid_0 !== 1'b0) begin errors++; $display("FAIL reset_v0: got %b want 0", out_valid_0); end
        checks++; if (out_valid_1 !== 1'b0) begin errors++; $display("FAIL reset_v1: got %b want 0", out_valid_1); end
        checks++; if (out_inst_0 !== 32'h0) begin errors++; $display("FAIL reset_inst0: got %h want 0", out_inst_0); end
        checks++; if (out_inst_1 !== 32'h0) begin errors++; $display("FAIL reset_inst1: got %h want 0", out_inst_1); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
`ifdef ISSUE_CTRL_PERF_EN
        checks++; if (perf_split !== 32'd0) begin errors++; $display("FAIL reset_psplit: got %0d want 0", perf_split); end
        checks++; if (perf_bubble !== 32'd0) begin errors++; $display("FAIL reset_pbubble: got %0d want 0", perf_bubble); end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_independent();
        drive_slot0(32'hA000_0001, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0);
        drive_slot1(32'hB000_0002, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL indep_ready: got %b want 1", in_ready); end
        step();
        drive_idle();
        #1;
        checks++; if (out_valid_0 !== 1'b1) begin errors++; $display("FAIL indep_v0: got %b want 1", out_valid_0); end
        checks++; if (out_valid_1 !== 1'b1) begin errors++; $display("FAIL indep_v1: got %b want 1", out_valid_1); end
        checks++; if (out_inst_0 !== 32'hA000_0001) begin errors++; $display("FAIL indep_inst0: got %h want a0000001", out_inst_0); end
        checks++; if (out_inst_1 !== 32'hB000_0002) begin errors++; $display("FAIL indep_inst1: got %h want b0000002", out_inst_1); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL indep_ready2: got %b want 1", in_ready); end
        step();
    endtask

    task automatic test_raw_split();
        drive_slot0(32'h0000_0011, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        drive_slot1(32'h0000_0022, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
        step();
        drive_idle();
        #1;
        checks++; if (out_valid_0 !== 1'b1 || out_inst_0 !== 32'h11) begin errors++; $display("FAIL raw_c1_s0: got v=%b inst=%h want v=1 inst=11", out_valid_0, out_inst_0); end
        checks++; if (out_valid_1 !== 1'b0) begin errors++; $display("FAIL raw_c1_v1: got %b want 0", out_valid_1); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_c1_ready: got %b want 0", in_ready); end
        step();
        checks++; if (out_valid_0 !== 1'b1 || out_inst_0 !== 32'h22) begin errors++; $display("FAIL raw_c2_s0: got v=%b inst=%h want v=1 inst=22", out_valid_0, out_inst_0); end
        checks++; if (out_valid_1 !== 1'b0) begin errors++; $display("FAIL raw_c2_v1: got %b want 0", out_valid_1); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_c2_ready: got %b want 1", in_ready); end
`ifdef ISSUE_CTRL_PERF_EN
        checks++; if (perf_split !== 32'd1) begin errors++; $display("FAIL raw_psplit: got %0d want 1", perf_split); end
`endif
        step();
        // WAW: rd_1 == rd_0 with slot 1 writing also splits.
        drive_slot0(32'h0000_0033, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
        drive_slot1(32'h0000_0044, 5'd3, 5'd4, 5'd9, 1'b1, 1'b0);
        step();
        drive_idle();
        checks++; if (out_valid_1 !== 1'b0) begin errors++; $display("FAIL waw_v1: got %b want 0", out_valid_1); end
        step();
        checks++; if (out_inst_0 !== 32'h44) begin errors++; $display("FAIL waw_inst0: got %h want 44", out_inst_0); end
        step();
    endtask

    task automatic test_zero_reg();
        drive_slot0(32'h0000_0055, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        drive_slot1(32'h0000_0066, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
        step();
        drive_idle();
        checks++; if (out_valid_0 !== 1'b1 || out_valid_1 !== 1'b1) begin errors++; $display("FAIL zero_pair: got v0=%b v1=%b want 1 1", out_valid_0, out_valid_1); end
        checks++; if (out_inst_1 !== 32'h66) begin errors++; $display("FAIL zero_inst1: got %h want 66", out_inst_1); end
        step();
    endtask

    task automatic test_load_use();
        drive_slot0(32'h0000_0077, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
        step();
        drive_idle();
        drive_slot0(32'h0000_0088, 5'd7, 5'd2, 5'd8, 1'b1, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL luse_ready: got %b want 0", in_ready); end
        step();
        checks++; if (out_valid_0 !== 1'b0 || out_valid_1 !== 1'b0) begin errors++; $display("FAIL luse_bubble: got v0=%b v1=%b want 0 0", out_valid_0, out_valid_1); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL luse_ready2: got %b want 1", in_ready); end
        step();
        drive_idle();
        checks++; if (out_valid_0 !== 1'b1 || out_inst_0 !== 32'h88) begin errors++; $display("FAIL luse_issue: got v=%b inst=%h want v=1 inst=88", out_valid_0, out_inst_0); end
`ifdef ISSUE_CTRL_PERF_EN
        checks++; if (perf_bubble !== 32'd1) begin errors++; $display("FAIL luse_pbubble: got %0d want 1", perf_bubble); end
`endif
        step();
    endtask

    task automatic test_load_split();
        drive_slot0(32'h0000_0099, 5'd1, 5'd0, 5'd10, 1'b1, 1'b1);
        drive_slot1(32'h0000_00AA, 5'd10, 5'd3, 5'd11, 1'b1, 1'b0);
        step();
        drive_idle();
        checks++; if (out_valid_0 !== 1'b1 || out_inst_0 !== 32'h99 || out_valid_1 !== 1'b0) begin errors++; $display("FAIL lsplit_c1: got v0=%b inst=%h v1=%b want 1 99 0", out_valid_0, out_inst_0, out_valid_1); end
        step();
        checks++; if (out_valid_0 !== 1'b0) begin errors++; $display("FAIL lsplit_bubble: got %b want 0", out_valid_0); end
        step();
        checks++; if (out_valid_0 !== 1'b1 || out_inst_0 !== 32'hAA) begin errors++; $display("FAIL lsplit_c3: got v=%b inst=%h want v=1 inst=aa", out_valid_0, out_inst_0); end
`ifdef ISSUE_CTRL_PERF_EN
        checks++; if (perf_split !== 32'd3) begin errors++; $display("FAIL lsplit_psplit: got %0d want 3", perf_split); end
        checks++; if (perf_bubble !== 32'd2) begin errors++; $display("FAIL lsplit_pbubble: got %0d want 2", perf_bubble); end
`endif
        step();
    endtask

    task automatic test_backpressure();
        drive_slot0(32'h0000_0BB0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        drive_slot1(32'h0000_0CC0, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0);
        step();
        drive_idle();
        out_ready = 1'b0;
        drive_slot0(32'h0000_0DD0, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
            checks++; if (out_valid_0 !== 1'b1 || out_valid_1 !== 1'b1 || out_inst_0 !== 32'hBB0 || out_inst_1 !== 32'hCC0) begin
                errors++; $display("FAIL bp_hold[%0d]: got v0=%b v1=%b i0=%h i1=%h want 1 1 bb0 cc0", i, out_valid_0, out_valid_1, out_inst_0, out_inst_1);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
        step();
        drive_idle();
        checks++; if (out_valid_0 !== 1'b1 || out_inst_0 !== 32'hDD0 || out_valid_1 !== 1'b0) begin errors++; $display("FAIL bp_issue: got v0=%b inst=%h v1=%b want 1 dd0 0", out_valid_0, out_inst_0, out_valid_1); end
        step();
    endtask

    task automatic test_flush();
        drive_slot0(32'h0000_0EE0, 5'd1, 5'd2, 5'd13, 1'b1, 1'b0);
        drive_slot1(32'h0000_0EE1, 5'd3, 5'd13, 5'd14, 1'b1, 1'b0);
        step();
        drive_idle();
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        step();
        flush = 1'b0;
        #1;
        checks++; if (out_valid_0 !== 1'b0 || out_valid_1 !== 1'b0) begin errors++; $display("FAIL flush_clear: got v0=%b v1=%b want 0 0", out_valid_0, out_valid_1); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_pair: got %b want 1", in_ready); end
        step();
        checks++; if (out_valid_0 !== 1'b0) begin errors++; $display("FAIL flush_h_gone: got %b want 0", out_valid_0); end
        // Flush coincident with an offered bundle blocks the accept.
        drive_slot0(32'h0000_0FF0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (out_valid_0 !== 1'b0) begin errors++; $display("FAIL flush_accept: got %b want 0", out_valid_0); end
        step();
        drive_idle();
        checks++; if (out_valid_0 !== 1'b1 || out_inst_0 !== 32'hFF0) begin errors++; $display("FAIL flush_after: got v=%b inst=%h want 1 ff0", out_valid_0, out_inst_0); end
`ifdef ISSUE_CTRL_PERF_EN
        checks++; if (perf_split !== 32'd4) begin errors++; $display("FAIL flush_psplit: got %0d want 4", perf_split); end
`endif
        step();
    endtask

    task automatic test_reset_mid_split();
        drive_slot0(32'h0000_1230, 5'd1, 5'd2, 5'd15, 1'b1, 1'b0);
        drive_slot1(32'h0000_1231, 5'd15, 5'd2, 5'd16, 1'b1, 1'b0);
        step();
        drive_idle();
        #1;
        rst = 1'b1;
        #1;
        checks++; if (out_valid_0 !== 1'b0 || out_inst_0 !== 32'h0) begin errors++; $display("FAIL rstmid_out: got v=%b inst=%h want 0 0", out_valid_0, out_inst_0); end
`ifdef ISSUE_CTRL_PERF_EN
        checks++; if (perf_split !== 32'd0 || perf_bubble !== 32'd0) begin errors++; $display("FAIL rstmid_perf: got %0d %0d want 0 0", perf_split, perf_bubble); end
`endif
        step();
        rst = 1'b0;
        step();
        checks++; if (out_valid_0 !== 1'b0) begin errors++; $display("FAIL rstmid_h_gone: got %b want 0", out_valid_0); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw_split();
        test_zero_reg();
        test_load_use();
        test_load_split();
        test_backpressure();
        test_flush();
        test_reset_mid_split();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
